// File: rtl/ls_dcache_unit.sv
// ls_dcache_unit
//   Direct-mapped write-back data cache with an uncached byte IO window. It serves one load or
//   store at a time for the load/store buffer. It owns the line port to the memory controller and
//   the byte IO port. A dirty victim is written back before its set is refilled.
//   Optional feature: define DCACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt counter outputs.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   rdy                global enable; low freezes all state and outputs
//   req_*              request from the load/store buffer (accept = req_valid && req_ready)
//   kill               squash the pending load response
//   resp_*             load response pulse with ROB id and extended data
//   mem_*              line read/write transactions (done on mem_ready pulse)
//   io_*               byte IO transactions for addresses >= IO_BASE (done on io_ready pulse)
//   hit_cnt, miss_cnt  lookup counters (DCACHE_PERF_CNT_EN only)
module ls_dcache_unit #(
   parameter int unsigned LINE_BYTES   = 16,
   parameter int unsigned SETS         = 16,
   parameter int unsigned ROB_ID_WIDTH = 4,
   parameter logic [31:0] IO_BASE      = 32'h30000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_rw,
   input  logic [1:0]                req_size,
   input  logic                      req_sign,
   input  logic [31:0]               req_addr,
   input  logic [31:0]               req_wdata,
   input  logic [ROB_ID_WIDTH-1:0]   req_dest,
   input  logic                      kill,
   output logic                      resp_valid,
   output logic [ROB_ID_WIDTH-1:0]   resp_dest,
   output logic [31:0]               resp_data,
   output logic                      mem_valid,
   output logic                      mem_rw,
   output logic [31:0]               mem_addr,
   output logic [LINE_BYTES*8-1:0]   mem_wline,
   input  logic                      mem_ready,
   input  logic [LINE_BYTES*8-1:0]   mem_rline,
   output logic                      io_valid,
   output logic                      io_rw,
   output logic [31:0]               io_addr,
   output logic [7:0]                io_wbyte,
   input  logic                      io_ready,
   input  logic [7:0]                io_rbyte
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]               hit_cnt,
   output logic [31:0]               miss_cnt
`endif
);

   localparam int unsigned OFF_W = $clog2(LINE_BYTES);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 32 - OFF_W - IDX_W;
   localparam int unsigned LW    = LINE_BYTES * 8;

   typedef enum logic [2:0] {StIdle, StTag, StWb, StRefill, StIo} state_e;
   state_e state_q, state_d;

   // Latched request
   logic                    rw_q, rw_d, sign_q, sign_d, killed_q, killed_d, first_q, first_d;
   logic [1:0]              size_q, size_d;
   logic [31:0]             addr_q, addr_d, wdata_q, wdata_d;
   logic [ROB_ID_WIDTH-1:0] dest_q, dest_d;

   // Registered outputs
   logic                    resp_valid_d, mem_valid_d, mem_rw_d, io_valid_d, io_rw_d;
   logic [ROB_ID_WIDTH-1:0] resp_dest_d;
   logic [31:0]             resp_data_d, mem_addr_d, io_addr_d;
   logic [LW-1:0]           mem_wline_d;
   logic [7:0]              io_wbyte_d;

   // Cache arrays
   logic [LW-1:0]    line_q [SETS];
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [SETS-1:0]  valid_q, dirty_q;

   logic             line_we, install, set_dirty, clr_dirty;
   logic [LW-1:0]    line_wdata;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [OFF_W-1:0] off;
   logic             hit;
   logic [LW-1:0]    cur_line, rd_line, merged, wext, wshift;
   logic [LINE_BYTES-1:0] bmask;

   function automatic logic [31:0] extend(input logic [1:0] size, input logic sign,
                                          input logic [31:0] d);
      case (size)
         2'd0:    return sign ? {{24{d[7]}}, d[7:0]} : {24'b0, d[7:0]};
         2'd1:    return sign ? {{16{d[15]}}, d[15:0]} : {16'b0, d[15:0]};
         default: return d;
      endcase
   endfunction

   assign idx       = addr_q[OFF_W +: IDX_W];
   assign tag       = addr_q[31 -: TAG_W];
   assign off       = addr_q[OFF_W-1:0];
   assign cur_line  = line_q[idx];
   assign hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign req_ready = (state_q == StIdle);
   assign rd_line   = cur_line >> {off, 3'b000};

   // Store merge: shift the store data and its byte mask to the line offset
   always_comb begin
      wext       = '0;
      wext[31:0] = wdata_q;
      wshift     = wext << {off, 3'b000};
      bmask      = '0;
      case (size_q)
         2'd0:    bmask[0]   = 1'b1;
         2'd1:    bmask[1:0] = 2'b11;
         default: bmask[3:0] = 4'hf;
      endcase
      bmask = bmask << off;
      for (int unsigned i = 0; i < LINE_BYTES; i++) begin
         merged[8*i +: 8] = bmask[i] ? wshift[8*i +: 8] : cur_line[8*i +: 8];
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else if (rdy) begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (req_valid) state_d = (req_addr >= IO_BASE) ? StIo : StTag;
         StTag:    if (hit) state_d = StIdle;
                   else if (valid_q[idx] && dirty_q[idx]) state_d = StWb;
                   else state_d = StRefill;
         StWb:     if (mem_ready) state_d = StRefill;
         StRefill: if (mem_ready) state_d = StTag;
         StIo:     if (io_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs and datapath next values
   always_comb begin
      rw_d = rw_q;  sign_d = sign_q;  size_d = size_q;  addr_d = addr_q;
      wdata_d = wdata_q;  dest_d = dest_q;  killed_d = killed_q;  first_d = first_q;
      resp_valid_d = 1'b0;  resp_dest_d = resp_dest;  resp_data_d = resp_data;
      mem_valid_d = mem_valid;  mem_rw_d = mem_rw;  mem_addr_d = mem_addr;
      mem_wline_d = mem_wline;
      io_valid_d = io_valid;  io_rw_d = io_rw;  io_addr_d = io_addr;  io_wbyte_d = io_wbyte;
      line_we = 1'b0;  line_wdata = merged;  install = 1'b0;
      set_dirty = 1'b0;  clr_dirty = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               rw_d = req_rw;  size_d = req_size;  sign_d = req_sign;  addr_d = req_addr;
               wdata_d = req_wdata;  dest_d = req_dest;  killed_d = 1'b0;  first_d = 1'b1;
               if (req_addr >= IO_BASE) begin
                  io_valid_d = 1'b1;  io_rw_d = req_rw;
                  io_addr_d  = req_addr;  io_wbyte_d = req_wdata[7:0];
               end
            end
         end
         StTag: begin
            if (hit) begin
               if (rw_q) begin
                  line_we   = 1'b1;
                  set_dirty = 1'b1;
               end else if (dest_q != '0 && !killed_q && !kill) begin
                  resp_valid_d = 1'b1;  resp_dest_d = dest_q;
                  resp_data_d  = extend(size_q, sign_q, rd_line[31:0]);
               end
            end else if (valid_q[idx] && dirty_q[idx]) begin
               mem_valid_d = 1'b1;  mem_rw_d = 1'b1;
               mem_addr_d  = {tag_q[idx], idx, {OFF_W{1'b0}}};
               mem_wline_d = cur_line;
            end else begin
               mem_valid_d = 1'b1;  mem_rw_d = 1'b0;
               mem_addr_d  = {tag, idx, {OFF_W{1'b0}}};
            end
         end
         StWb: begin
            // The refill request follows the write-back without dropping mem_valid
            if (mem_ready) begin
               clr_dirty  = 1'b1;  mem_rw_d = 1'b0;
               mem_addr_d = {tag, idx, {OFF_W{1'b0}}};
            end
         end
         StRefill: begin
            if (mem_ready) begin
               line_we = 1'b1;  line_wdata = mem_rline;  install = 1'b1;
               mem_valid_d = 1'b0;  first_d = 1'b0;
            end
         end
         StIo: begin
            if (io_ready) begin
               io_valid_d = 1'b0;
               if (!rw_q && dest_q != '0 && !killed_q && !kill) begin
                  resp_valid_d = 1'b1;  resp_dest_d = dest_q;
                  resp_data_d  = extend(size_q, sign_q, {24'b0, io_rbyte});
               end
            end
         end
         default: ;
      endcase
      if (state_q != StIdle && kill && !rw_q) killed_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rw_q <= 1'b0;  sign_q <= 1'b0;  size_q <= '0;  addr_q <= '0;  wdata_q <= '0;
         dest_q <= '0;  killed_q <= 1'b0;  first_q <= 1'b0;
         resp_valid <= 1'b0;  resp_dest <= '0;  resp_data <= '0;
         mem_valid <= 1'b0;  mem_rw <= 1'b0;  mem_addr <= '0;  mem_wline <= '0;
         io_valid <= 1'b0;  io_rw <= 1'b0;  io_addr <= '0;  io_wbyte <= '0;
         valid_q <= '0;  dirty_q <= '0;
      end else if (rdy) begin
         rw_q <= rw_d;  sign_q <= sign_d;  size_q <= size_d;  addr_q <= addr_d;
         wdata_q <= wdata_d;  dest_q <= dest_d;  killed_q <= killed_d;  first_q <= first_d;
         resp_valid <= resp_valid_d;  resp_dest <= resp_dest_d;  resp_data <= resp_data_d;
         mem_valid <= mem_valid_d;  mem_rw <= mem_rw_d;  mem_addr <= mem_addr_d;
         mem_wline <= mem_wline_d;
         io_valid <= io_valid_d;  io_rw <= io_rw_d;  io_addr <= io_addr_d;
         io_wbyte <= io_wbyte_d;
         if (install) valid_q[idx] <= 1'b1;
         if (set_dirty) dirty_q[idx] <= 1'b1;
         if (clr_dirty || install) dirty_q[idx] <= 1'b0;
      end
   end

   // Line data and tags need no reset: valid bits guard them
   always_ff @(posedge clk) begin
      if (!rst && rdy) begin
         if (line_we) line_q[idx] <= line_wdata;
         if (install) tag_q[idx] <= tag;
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   // Only the first lookup of a request counts as a hit; post-refill re-lookups are skipped
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (rdy && state_q == StTag) begin
         if (hit && first_q) hit_cnt <= hit_cnt + 32'd1;
         if (!hit) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule
